vga_pattern_ctrl: RTL

Frame-synchronous test-pattern controller for the 800x600 SVGA output path. It sits between the VGA sync generator (which supplies `isReady`, `x` and `y`) and the 1-bit RGB pins. It selects one of four display patterns and advances the selection automatically every N frames or on a manual request. Pattern changes are applied only in vertical blanking, so a frame never tears.

---
 rtl/vga_pattern_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vga_pattern_ctrl.sv
`timescale 1ns/1ps
// vga_pattern_ctrl
// Frame-synchronous test-pattern generator for the 800x600 SVGA path.
// Cycles through four patterns (BARS, CHECKER, BORDER, SOLID), advancing
// every FRAMES_PER_PATTERN frames when auto_en is high or on a manual
// next_req. Pattern changes only take effect on the last visible pixel of a
// frame, so no frame ever shows two patterns.
//
// Ports:
//   clk_control  pixel clock, rising edge
//   rst_n        asynchronous active-low reset
//   isReady      x/y address a visible pixel
//   x, y         visible column/row from the sync generator
//   auto_en      enables frame-count auto-advance (level)
//   next_req     one-cycle manual advance request
//   red_sig, green_sig, blue_sig  registered 1-bit colour outputs
//   pattern_id   current pattern (0 BARS, 1 CHECKER, 2 BORDER, 3 SOLID)
//   frame_tick   one-cycle pulse after the last visible pixel of a frame
module vga_pattern_ctrl #(
  parameter int H_ACTIVE           = 800,
  parameter int V_ACTIVE           = 600,
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int CHECK_SHIFT        = 5
) (
  input  logic        clk_control,
  input  logic        rst_n,
  input  logic        isReady,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        auto_en,
  input  logic        next_req,
  output logic        red_sig,
  output logic        green_sig,
  output logic        blue_sig,
  output logic [1:0]  pattern_id,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    CHECKER = 2'd1,
    BORDER  = 2'd2,
    SOLID   = 2'd3
  } pattern_t;

  localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_ACTIVE - 1);
  localparam int          BAR_W    = H_ACTIVE / 8;
  localparam logic [7:0]  CNT_LAST = 8'(FRAMES_PER_PATTERN - 1);

  pattern_t   state;
  pattern_t   state_next;
  logic [7:0] frame_cnt;
  logic [7:0] frame_cnt_next;
  logic       pending;
  logic       pending_next;
  logic [2:0] solid_color;
  logic [2:0] solid_next;
  logic [2:0] bar_idx;
  logic [2:0] pixel_color;
  logic       frame_end;
  logic       advance;

  assign frame_end = isReady && (x == X_LAST) && (y == Y_LAST);

  // Any combination of pending, a coincident request and the auto count
  // produces a single advance.
  assign advance = frame_end &&
                   (pending || next_req || (auto_en && (frame_cnt == CNT_LAST)));

  always_ff @(posedge clk_control or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BARS;
      frame_cnt   <= 8'd0;
      pending     <= 1'b0;
      solid_color <= 3'd1;
    end else begin
      state       <= state_next;
      frame_cnt   <= frame_cnt_next;
      pending     <= pending_next;
      solid_color <= solid_next;
    end
  end

  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    pending_next   = pending;
    solid_next     = solid_color;
    if (next_req) begin
      pending_next = 1'b1;
    end
    if (advance) begin
      pending_next   = 1'b0;
      frame_cnt_next = 8'd0;
      case (state)
        BARS:    state_next = CHECKER;
        CHECKER: state_next = BORDER;
        BORDER: begin
          state_next = SOLID;
          // Colour cycles 1..7 and skips 0 so SOLID is never black.
          solid_next = (solid_color == 3'd7) ? 3'd1 : solid_color + 3'd1;
        end
        default: state_next = BARS;
      endcase
    end else if (frame_end) begin
      frame_cnt_next = auto_en ? frame_cnt + 8'd1 : 8'd0;
    end
  end

  // Bar index is the number of bar boundaries at or left of x; avoids a
  // divider.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 11'(i * BAR_W)) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
  end

  always_comb begin
    pixel_color = 3'd0;
    case (state)
      BARS:    pixel_color = 3'd7 - bar_idx;
      CHECKER: pixel_color = (x[CHECK_SHIFT] ^ y[CHECK_SHIFT]) ? 3'd7 : 3'd0;
      BORDER:  pixel_color = ((x == 11'd0) || (x == X_LAST) ||
                              (y == 11'd0) || (y == Y_LAST)) ? 3'd7 : 3'd0;
      default: pixel_color = solid_color;
    endcase
  end

  always_ff @(posedge clk_control or negedge rst_n) begin
    if (!rst_n) begin
      red_sig    <= 1'b0;
      green_sig  <= 1'b0;
      blue_sig   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      {red_sig, green_sig, blue_sig} <= isReady ? pixel_color : 3'd0;
      frame_tick                     <= frame_end;
    end
  end

  assign pattern_id = state;

endmodule
